// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential shift-add multiplier, signed/unsigned, one bit per clock
module shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]   acc;
  logic            neg;

  logic            capture;
  logic            last;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]  sum;
  logic [PW-1:0]   acc_next;
  logic [PW-1:0]   result;

  // Operand magnitudes and one iteration of the add-then-shift datapath
  always_comb begin
    a_mag    = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag    = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    // Carry out of the upper half is kept so the shift never drops a bit
    sum      = {1'b0, acc[PW-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_next = {sum, acc[WIDTH-1:1]};
    result   = neg ? (~acc_next + PW'(1)) : acc_next;
    last     = (cnt == CW'(WIDTH - 1));
  end

  // Next-state logic; start is only honoured in IDLE and DONE
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, registered status outputs, operand capture and iteration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      neg     <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
      if (capture) begin
        mcand  <= a_mag;
        mplier <= b_mag;
        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc    <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        acc    <= acc_next;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        // Product only moves on the completing edge
        if (last) product <= result;
      end
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - scoreboard bench for shift_add_multiplier (WIDTH=16 and WIDTH=4)
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst16 = 1'b1, start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  logic [31:0] prod16;

  logic        rst4 = 1'b1, start4 = 1'b0, sm4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  prod4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q16[$];
  logic [7:0]  q4[$];
  logic [31:0] prev_prod16 = '0;

  shift_add_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .signed_mode(sm16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .product(prod16)
  );

  shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .product(prod4)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref4(input logic m, input logic [3:0] x, input logic [3:0] y);
    int sx, sy;
    sx = (m && x[3]) ? int'(x) - 16 : int'(x);
    sy = (m && y[3]) ? int'(y) - 16 : int'(y);
    return 8'(sx * sy);
  endfunction

  // WIDTH=16 monitor: pops the scoreboard on done, checks hold and exclusivity
  always @(negedge clk) begin
    if (!rst16) begin
      if (busy16 && done16) check("busy_done_excl16", 64'(1), 64'(0));
      if (busy16) check("hold16", 64'(prod16), 64'(prev_prod16));
      if (done16) begin
        if (q16.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done16: product 0x%0h, no result expected", prod16);
        end else begin
          check("product16", 64'(prod16), 64'(q16.pop_front()));
        end
      end
    end
    prev_prod16 = prod16;
  end

  // WIDTH=4 monitor
  always @(negedge clk) begin
    if (!rst4 && done4) begin
      if (q4.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done4: product 0x%0h, no result expected", prod4);
      end else begin
        check("product4", 64'(prod4), 64'(q4.pop_front()));
      end
    end
  end

  task automatic wait_done16(output int bc);
    int t;
    bc = 0;
    t  = 0;
    while (!done16 && t < 100) begin
      if (busy16) bc++;
      @(negedge clk);
      t++;
    end
    if (!done16) check("timeout16", 64'(t), 64'(0));
  endtask

  task automatic run16(input logic m, input logic [15:0] x, input logic [15:0] y, input logic [31:0] exp, output int bc);
    @(negedge clk);
    start16 = 1'b1; sm16 = m; a16 = x; b16 = y;
    q16.push_back(exp);
    @(negedge clk);
    start16 = 1'b0; sm16 = ~m; a16 = 16'($urandom); b16 = 16'($urandom);
    wait_done16(bc);
  endtask

  task automatic run4(input logic m, input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp);
    int t;
    @(negedge clk);
    start4 = 1'b1; sm4 = m; a4 = x; b4 = y;
    q4.push_back(exp);
    @(negedge clk);
    start4 = 1'b0; a4 = ~x; b4 = ~y;
    t = 0;
    while (!done4 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!done4) check("timeout4", 64'(t), 64'(0));
  endtask

  // Global safety net
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bc;
    int t;

    repeat (3) @(negedge clk);
    check("rst_busy16", 64'(busy16), 64'(0));
    check("rst_done16", 64'(done16), 64'(0));
    check("rst_prod16", 64'(prod16), 64'(0));
    check("rst_prod4",  64'(prod4),  64'(0));
    rst16 = 1'b0;
    rst4  = 1'b0;

    // 3*5 with latency checks
    run16(1'b0, 16'd3, 16'd5, 32'h0000_000F, bc);
    check("busy_cycles16", 64'(bc), 64'(16));
    check("done_high16", 64'(done16), 64'(1));
    @(negedge clk);
    check("done_low16", 64'(done16), 64'(0));
    check("idle_busy16", 64'(busy16), 64'(0));

    run16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, bc);
    run16(1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001, bc);
    run16(1'b1, 16'h8000, 16'h8000, 32'h4000_0000, bc);
    run16(1'b1, 16'hFFFD, 16'h0007, 32'hFFFF_FFEB, bc);
    run16(1'b1, 16'h8000, 16'h0001, 32'hFFFF_8000, bc);
    run16(1'b0, 16'h0000, 16'h1234, 32'h0000_0000, bc);
    check("zero_busy_cycles16", 64'(bc), 64'(16));

    // start held high, operands changing every cycle: captures at E0, E17, E34
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      start16 = 1'b1; sm16 = 1'b0;
      a16 = 16'h0100 + 16'(i);
      b16 = 16'h0011 + 16'(i);
      if (i == 0)  q16.push_back(32'h0000_1100);
      if (i == 17) q16.push_back(32'h0000_2442);
      if (i == 34) q16.push_back(32'h0000_39C6);
    end
    @(negedge clk);
    start16 = 1'b0;
    t = 0;
    while (q16.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("b2b_drain16", 64'(q16.size()), 64'(0));

    // start pulse during RUN must be ignored
    @(negedge clk);
    @(negedge clk);
    start16 = 1'b1; sm16 = 1'b0; a16 = 16'd100; b16 = 16'd200;
    q16.push_back(32'd20000);
    @(negedge clk);
    start16 = 1'b0;
    repeat (5) @(negedge clk);
    start16 = 1'b1; a16 = 16'd7; b16 = 16'd7;
    @(negedge clk);
    start16 = 1'b0;
    wait_done16(bc);
    repeat (25) @(negedge clk);
    check("ignored_start_busy16", 64'(busy16), 64'(0));

    // reset sampled at E8 of a run aborts it
    @(negedge clk);
    start16 = 1'b1; sm16 = 1'b0; a16 = 16'd7; b16 = 16'd9;
    @(negedge clk);
    start16 = 1'b0;
    repeat (6) @(negedge clk);
    @(negedge clk);
    rst16 = 1'b1;
    @(negedge clk);
    check("abort_busy16", 64'(busy16), 64'(0));
    check("abort_done16", 64'(done16), 64'(0));
    check("abort_prod16", 64'(prod16), 64'(0));
    rst16 = 1'b0;
    repeat (20) @(negedge clk);
    run16(1'b0, 16'd1234, 16'd10, 32'd12340, bc);
    check("post_abort_busy_cycles16", 64'(bc), 64'(16));

    // WIDTH=4: directed corners, then exhaustive against the model
    run4(1'b0, 4'hF, 4'hF, 8'hE1);
    run4(1'b1, 4'h8, 4'h8, 8'h40);
    run4(1'b1, 4'hF, 4'h7, 8'hF9);
    for (int m = 0; m < 2; m++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          run4(1'(m), 4'(x), 4'(y), ref4(1'(m), 4'(x), 4'(y)));

    repeat (5) @(negedge clk);
    check("q16_empty", 64'(q16.size()), 64'(0));
    check("q4_empty",  64'(q4.size()),  64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Parametrised sequential multiplier that computes the full-width product of two WIDTH-bit operands, signed or unsigned, by iterating one multiplier bit per clock through a shared WIDTH-bit ripple adder. It succeeds the combinational 4/8/16-bit adder and add/sub chain, trading area for latency. It serves as the multiply unit for the datapath that already uses those adders. Start/busy/done handshake; result held until the next operation completes.

## Interface
- WIDTH, 16, operand width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only when state is IDLE or DONE
- signed_mode  input  1  1 = operands are two's complement, 0 = unsigned; captured with start
- a  input  WIDTH  multiplicand; captured with start
- b  input  WIDTH  multiplier; captured with start
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse, product valid and newly updated
- product  output  2*WIDTH  result register

## Operation
- States: IDLE, RUN, DONE.
- Reset (rst=1 at an edge) forces IDLE, busy=0, done=0, product=0, iteration counter=0, internal registers=0; this has priority over all other inputs, including mid-RUN (operation aborted, no done pulse).
- Capture (start=1 at an edge in IDLE or DONE):
  - latch magnitudes |a|, |b| (unsigned: as-is; signed: negate if MSB set; the most negative value maps to 2^(WIDTH-1), fits in WIDTH unsigned bits);
  - latch neg = signed_mode & (a[MSB] ^ b[MSB]);
  - clear partial product (2*WIDTH bits) and counter; go to RUN.
- RUN, one iteration per edge, counter 0..WIDTH-1:
  - if the current multiplier LSB is 1, add the multiplicand magnitude into the upper WIDTH bits of the partial product, keeping the WIDTH+1-bit carry;
  - shift {carry, partial product} right by one.
  - On the iteration with counter=WIDTH-1, write product = neg ? two's-complement(partial) : partial (2*WIDTH-bit negate, result modulo 2^(2*WIDTH)); go to DONE.
- DONE lasts one cycle: done=1. Next edge: to RUN if start=1 (back-to-back capture), otherwise to IDLE.
- start in RUN is ignored; it is not queued.
- a, b and signed_mode may change freely after capture.
- product changes only on the completing edge or on reset; it holds its old value throughout RUN.
- Zero operands run the full WIDTH iterations; there is no early termination.

## Timing
- Edge E0 samples start=1. busy=1 from after E0 through the cycle before EW.
- Edges E1..EW perform the WIDTH iterations. The final iteration and product write happen at EW.
- After EW: busy=0, done=1, product valid.
- After E(W+1): done=0, state IDLE (or RUN again if start=1 at E(W+1)).
- Latency from start edge to done cycle: WIDTH edges. Throughput: one result per WIDTH+1 cycles with start held high.
- busy and done are never high simultaneously. All outputs are registered.

## Test plan
- WIDTH=16, unsigned, a=3, b=5: start at E0 -> busy high 16 cycles, done pulse after E16, product=0x0000000F, done low after E17.
- WIDTH=16, unsigned, a=b=0xFFFF -> product=0xFFFE0001. Then signed, a=b=0xFFFF (-1*-1) -> product=0x00000001.
- WIDTH=16, signed: a=0x8000, b=0x8000 -> product=0x40000000; a=0xFFFD (-3), b=0x0007 -> product=0xFFFFFFEB (-21); a=0x8000, b=0x0001 -> product=0xFFFF8000.
- WIDTH=16, start held high with a/b changing every cycle -> results correspond to the operands captured at E0, E17, E34. start pulses during RUN are ignored, and product stays stable during RUN.
- rst=1 at E8 of a run -> busy=0, done=0, product=0 after E8, with no done pulse. A fresh start then completes normally with the correct result.
- WIDTH=4 instance: exhaustive 256 operand pairs in both modes against a reference model. Unsigned 15*15=225 (0xE1); signed -8*-8 = 0x40.
